// File: rtl/data_memory_unit.sv
// rtl/data_memory_unit.sv - RV32 data memory with valid/ready requests, fixed-latency response and clear sweep
//
// Purpose:
//   Word-organised data store for the load/store stage. It handles sub-word
//   stores with byte-lane enables and sign/zero-extended sub-word loads. It
//   also flags range, alignment and funct3 faults. After reset a hardware
//   sweep zeroes the array one word per cycle and writes a single preset word.
//
// Ports:
//   clk         rising-edge clock
//   reset_n     asynchronous active-low reset
//   req_valid   request present (held by requester until accepted)
//   req_ready   unit accepts a request on this edge
//   req_write   1 = store, 0 = load
//   req_funct3  RV32 funct3 (LB/LH/LW/LBU/LHU, SB/SH/SW)
//   req_addr    byte address
//   req_wdata   store data, low byte/half/word used
//   resp_valid  one-cycle response pulse
//   resp_rdata  extended load data, 0 for stores and faults
//   resp_error  fault flag, qualified by resp_valid
//   init_done   clear sweep has completed

module data_memory_unit #(
   parameter int unsigned DEPTH_WORDS  = 768,
   parameter logic [31:0] BASE_ADDR    = 32'h0000_0000,
   parameter int unsigned LATENCY      = 1,
   parameter int unsigned PRESET_INDEX = 5,
   parameter logic [31:0] PRESET_VALUE = 32'hFFFF_FFE0,
   parameter bit          NULL_GUARD   = 1'b1
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_write,
   input  logic [2:0]  req_funct3,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   output logic        resp_valid,
   output logic [31:0] resp_rdata,
   output logic        resp_error,
   output logic        init_done
);

   localparam int unsigned IDX_W = $clog2(DEPTH_WORDS);

   typedef enum logic [1:0] {
      ST_CLEAR,
      ST_IDLE,
      ST_BUSY
   } state_t;

   state_t            state;
   logic [IDX_W-1:0]  clr_idx;
   logic [2:0]        lat_cnt;
   logic              lat_write;
   logic [2:0]        lat_funct3;
   logic [31:0]       lat_addr;
   logic [31:0]       lat_wdata;

   logic [31:0]       mem [DEPTH_WORDS];

   // Decode of the latched request
   logic [31:0]       offset;
   logic [1:0]        lane;
   logic [IDX_W-1:0]  word_idx;
   logic              below_base;
   logic              beyond_top;
   logic              misaligned;
   logic              bad_funct3;
   logic              fault;
   logic              null_drop;
   logic              resp_cycle;
   logic              commit;
   logic [3:0]        st_be;
   logic [31:0]       st_data;
   logic [31:0]       rd_word;
   logic [31:0]       rd_shift;
   logic [31:0]       load_data;

   always_comb begin
      offset     = lat_addr - BASE_ADDR;
      lane       = offset[1:0];
      word_idx   = offset[IDX_W+1:2];
      below_base = (lat_addr < BASE_ADDR);
      // Compare the full word offset so addresses far above the array cannot alias
      beyond_top = ({2'b00, offset[31:2]} >= 32'(DEPTH_WORDS));

      case (lat_funct3[1:0])
         2'b01:   misaligned = lane[0];
         2'b10:   misaligned = (lane != 2'b00);
         default: misaligned = 1'b0;
      endcase

      if (lat_write)
         bad_funct3 = (lat_funct3 > 3'd2);
      else
         bad_funct3 = (lat_funct3 == 3'b011) || (lat_funct3[2:1] == 2'b11);

      fault      = below_base || beyond_top || misaligned || bad_funct3;
      null_drop  = NULL_GUARD && (word_idx == '0);
      resp_cycle = (state == ST_BUSY) && (lat_cnt == 3'd1);
      commit     = resp_cycle && lat_write && !fault && !null_drop;

      st_data = lat_wdata << {lane, 3'b000};
      case (lat_funct3[1:0])
         2'b00:   st_be = 4'b0001 << lane;
         2'b01:   st_be = 4'b0011 << lane;
         default: st_be = 4'b1111;
      endcase

      // Faulting requests may carry an index past the array; never read it
      rd_word  = fault ? '0 : mem[word_idx];
      rd_shift = rd_word >> {lane, 3'b000};
      case (lat_funct3)
         3'b000:  load_data = {{24{rd_shift[7]}},  rd_shift[7:0]};
         3'b001:  load_data = {{16{rd_shift[15]}}, rd_shift[15:0]};
         3'b100:  load_data = {24'h000000, rd_shift[7:0]};
         3'b101:  load_data = {16'h0000,   rd_shift[15:0]};
         default: load_data = rd_word;
      endcase

      resp_rdata = (resp_valid && !lat_write && !fault) ? load_data : '0;
      resp_error = resp_valid && fault;
   end

   // Control FSM; resp_valid is registered one edge ahead of the response cycle
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state      <= ST_CLEAR;
         clr_idx    <= '0;
         lat_cnt    <= '0;
         lat_write  <= 1'b0;
         lat_funct3 <= '0;
         lat_addr   <= '0;
         lat_wdata  <= '0;
         req_ready  <= 1'b0;
         resp_valid <= 1'b0;
         init_done  <= 1'b0;
      end else begin
         case (state)
            ST_CLEAR: begin
               if (clr_idx == IDX_W'(DEPTH_WORDS - 1)) begin
                  state     <= ST_IDLE;
                  init_done <= 1'b1;
                  req_ready <= 1'b1;
               end else begin
                  clr_idx <= clr_idx + IDX_W'(1);
               end
            end
            ST_IDLE: begin
               if (req_valid) begin
                  lat_write  <= req_write;
                  lat_funct3 <= req_funct3;
                  lat_addr   <= req_addr;
                  lat_wdata  <= req_wdata;
                  lat_cnt    <= 3'(LATENCY);
                  state      <= ST_BUSY;
                  req_ready  <= 1'b0;
                  resp_valid <= (LATENCY == 1);
               end
            end
            ST_BUSY: begin
               if (lat_cnt == 3'd1) begin
                  state      <= ST_IDLE;
                  req_ready  <= 1'b1;
                  resp_valid <= 1'b0;
               end else begin
                  lat_cnt    <= lat_cnt - 3'd1;
                  resp_valid <= (lat_cnt == 3'd2);
               end
            end
            default: state <= ST_CLEAR;
         endcase
      end
   end

   // Array: sweep writes during clear, byte-enabled commit at the end of the
   // response cycle. The FSM state is reset asynchronously, so an in-flight
   // store cannot commit once reset_n has fallen.
   always_ff @(posedge clk) begin
      if (state == ST_CLEAR) begin
         mem[clr_idx] <= (clr_idx == IDX_W'(PRESET_INDEX)) ? PRESET_VALUE : '0;
      end else if (commit) begin
         for (int b = 0; b < 4; b++) begin
            if (st_be[b])
               mem[word_idx][8*b +: 8] <= st_data[8*b +: 8];
         end
      end
   end

endmodule

// File: tb/tb_data_memory_unit.sv
// tb/tb_data_memory_unit.sv - self-checking bench for data_memory_unit

module tb_data_memory_unit;

   localparam int unsigned DEPTH   = 16;
   localparam logic [31:0] BASE    = 32'h0000_0100;
   localparam int unsigned LAT     = 3;
   localparam int unsigned PRE_IDX = 5;
   localparam logic [31:0] PRE_VAL = 32'hFFFF_FFE0;

   logic        clk;
   logic        reset_n;
   logic        req_valid;
   logic        req_ready;
   logic        req_write;
   logic [2:0]  req_funct3;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;
   logic        resp_valid;
   logic [31:0] resp_rdata;
   logic        resp_error;
   logic        init_done;

   int total = 0;
   int bad   = 0;
   int cyc   = 0;
   int last_acc = 0;

   logic [7:0] ref_b [DEPTH*4];

   data_memory_unit #(
      .DEPTH_WORDS (DEPTH),
      .BASE_ADDR   (BASE),
      .LATENCY     (LAT),
      .PRESET_INDEX(PRE_IDX),
      .PRESET_VALUE(PRE_VAL),
      .NULL_GUARD  (1'b1)
   ) dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .req_write  (req_write),
      .req_funct3 (req_funct3),
      .req_addr   (req_addr),
      .req_wdata  (req_wdata),
      .resp_valid (resp_valid),
      .resp_rdata (resp_rdata),
      .resp_error (resp_error),
      .init_done  (init_done)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #300000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] wa(input int idx, input int ln);
      return BASE + 32'(idx * 4 + ln);
   endfunction

   function automatic void model_init();
      logic [31:0] pv;
      pv = PRE_VAL;
      foreach (ref_b[i]) ref_b[i] = 8'h00;
      for (int k = 0; k < 4; k++) ref_b[PRE_IDX*4 + k] = pv[8*k +: 8];
   endfunction

   // Byte-array model: the memory is a flat little-endian byte store
   function automatic void model(input logic w, input logic [2:0] f3, input logic [31:0] a,
                                 input logic [31:0] d, output logic [31:0] rd, output logic er);
      logic        legal;
      int          size;
      longint      off;
      logic [63:0] val;
      rd = '0;
      er = 1'b0;
      if (w) legal = (f3 <= 3'd2);
      else   legal = (f3 == 3'd0 || f3 == 3'd1 || f3 == 3'd2 || f3 == 3'd4 || f3 == 3'd5);
      size = 1 << f3[1:0];
      off  = longint'(a) - longint'(BASE);
      if (!legal) er = 1'b1;
      if (off < 0 || off / 4 >= DEPTH) er = 1'b1;
      if (legal && (off % size) != 0) er = 1'b1;
      if (er) return;
      if (w) begin
         if (off / 4 != 0)
            for (int k = 0; k < size; k++) ref_b[int'(off) + k] = d[8*k +: 8];
      end else begin
         val = '0;
         for (int k = 0; k < size; k++) val = val | (64'(ref_b[int'(off) + k]) << (8*k));
         if (!f3[2] && size < 4 && val[8*size-1]) val = val | ({64{1'b1}} << (8*size));
         rd = val[31:0];
      end
   endfunction

   // One request; called at a negedge. Checks latency, ready shape and pulse width.
   task automatic xact(input logic w, input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] d, output logic [31:0] rd, output logic er);
      int n;
      int seen_at;
      int seen_cnt;
      logic ready_ok;
      rd = '0;
      er = 1'b0;
      req_write  = w;
      req_funct3 = f3;
      req_addr   = a;
      req_wdata  = d;
      req_valid  = 1'b1;
      n = 0;
      while (req_ready !== 1'b1 && n < 200) begin
         @(negedge clk);
         n++;
      end
      if (req_ready !== 1'b1) begin
         chk("accept_timeout", 32'(req_ready), 32'd1);
         req_valid = 1'b0;
         return;
      end
      @(posedge clk);
      #1;
      last_acc   = cyc;
      req_valid  = 1'b0;
      req_write  = 1'($urandom);
      req_funct3 = 3'($urandom);
      req_addr   = $urandom;
      req_wdata  = $urandom;
      seen_at  = 0;
      seen_cnt = 0;
      ready_ok = 1'b1;
      for (int k = 1; k <= int'(LAT) + 1; k++) begin
         @(negedge clk);
         if (k <= int'(LAT) && req_ready !== 1'b0) ready_ok = 1'b0;
         if (resp_valid === 1'b1) begin
            seen_cnt++;
            if (seen_at == 0) begin
               seen_at = k;
               rd = resp_rdata;
               er = resp_error;
            end
         end
      end
      chk("resp_latency", 32'(seen_at), 32'(LAT));
      chk("resp_pulse_count", 32'(seen_cnt), 32'd1);
      chk("ready_low_in_busy", 32'(ready_ok), 32'd1);
      chk("ready_returns", 32'(req_ready), 32'd1);
   endtask

   task automatic run(input logic w, input logic [2:0] f3, input logic [31:0] a,
                      input logic [31:0] d, output logic [31:0] rd, output logic er);
      logic [31:0] mrd;
      logic        mer;
      model(w, f3, a, d, mrd, mer);
      xact(w, f3, a, d, rd, er);
      chk($sformatf("rdata w=%0d f3=%0d a=%h", w, f3, a), rd, mrd);
      chk($sformatf("error w=%0d f3=%0d a=%h", w, f3, a), 32'(er), 32'(mer));
   endtask

   // Called at a negedge right after reset_n rises
   task automatic wait_init();
      int k;
      k = 0;
      while (req_ready !== 1'b1 && k < int'(DEPTH) + 10) begin
         @(negedge clk);
         k++;
      end
      chk("clear_cycles", 32'(k), 32'(DEPTH));
      chk("init_done", 32'(init_done), 32'd1);
      model_init();
   endtask

   initial begin
      logic [31:0] rd;
      logic        er;
      logic        no_resp;
      int          a0;
      logic [2:0]  f3;
      logic [31:0] a;

      reset_n    = 1'b0;
      req_valid  = 1'b0;
      req_write  = 1'b0;
      req_funct3 = 3'd0;
      req_addr   = '0;
      req_wdata  = '0;
      model_init();

      repeat (3) @(negedge clk);
      chk("rst_req_ready", 32'(req_ready), 32'd0);
      chk("rst_resp_valid", 32'(resp_valid), 32'd0);
      chk("rst_resp_rdata", resp_rdata, 32'd0);
      chk("rst_resp_error", 32'(resp_error), 32'd0);
      chk("rst_init_done", 32'(init_done), 32'd0);

      // Reset mid-clear restarts the sweep
      reset_n = 1'b1;
      repeat (5) @(negedge clk);
      reset_n = 1'b0;
      @(negedge clk);
      chk("midclear_init_done", 32'(init_done), 32'd0);
      reset_n = 1'b1;
      wait_init();

      // Preset and cleared words
      run(1'b0, 3'b010, wa(PRE_IDX, 0), 32'h0, rd, er);
      chk("lw_preset", rd, 32'hFFFF_FFE0);
      run(1'b0, 3'b010, wa(6, 0), 32'h0, rd, er);
      chk("lw_idx6", rd, 32'h0);

      // Byte lane store and extended byte loads
      run(1'b1, 3'b010, wa(8, 0), 32'h1122_3344, rd, er);
      run(1'b1, 3'b000, wa(8, 2), 32'h5555_55AA, rd, er);
      run(1'b0, 3'b010, wa(8, 0), 32'h0, rd, er);
      chk("lw_after_sb", rd, 32'h11AA_3344);
      run(1'b0, 3'b000, wa(8, 2), 32'h0, rd, er);
      chk("lb_lane2", rd, 32'hFFFF_FFAA);
      run(1'b0, 3'b100, wa(8, 2), 32'h0, rd, er);
      chk("lbu_lane2", rd, 32'h0000_00AA);

      // Halfword store/load, misaligned half
      run(1'b1, 3'b001, wa(9, 2), 32'hCDEF_8001, rd, er);
      run(1'b0, 3'b001, wa(9, 2), 32'h0, rd, er);
      chk("lh_lane2", rd, 32'hFFFF_8001);
      run(1'b0, 3'b101, wa(9, 2), 32'h0, rd, er);
      chk("lhu_lane2", rd, 32'h0000_8001);
      run(1'b1, 3'b001, wa(9, 1), 32'h0000_7777, rd, er);
      chk("sh_misaligned_err", 32'(er), 32'd1);
      run(1'b0, 3'b010, wa(9, 0), 32'h0, rd, er);
      chk("word9_unchanged", rd, 32'h8001_0000);

      // Faults and null guard
      run(1'b0, 3'b010, wa(DEPTH, 0), 32'h0, rd, er);
      chk("lw_oob_err", 32'(er), 32'd1);
      chk("lw_oob_rdata", rd, 32'h0);
      run(1'b0, 3'b011, wa(3, 0), 32'h0, rd, er);
      chk("ld_f3_011_err", 32'(er), 32'd1);
      run(1'b0, 3'b010, BASE - 32'd4, 32'h0, rd, er);
      chk("below_base_err", 32'(er), 32'd1);
      run(1'b1, 3'b010, wa(0, 0), 32'hDEAD_BEEF, rd, er);
      chk("null_guard_noerr", 32'(er), 32'd0);
      run(1'b0, 3'b010, wa(0, 0), 32'h0, rd, er);
      chk("null_guard_reads0", rd, 32'h0);

      // Back-to-back accept spacing
      run(1'b0, 3'b010, wa(1, 0), 32'h0, rd, er);
      a0 = last_acc;
      run(1'b0, 3'b010, wa(2, 0), 32'h0, rd, er);
      chk("accept_spacing", 32'(last_acc - a0), 32'(LAT + 1));

      // Randomized traffic against the byte-array model
      for (int n = 0; n < 200; n++) begin
         f3 = 3'($urandom_range(0, 7));
         a  = BASE - 32'd8 + 32'($urandom_range(0, DEPTH*4 + 15));
         if ($urandom_range(0, 1) == 1) a[1:0] = 2'b00;
         run(1'($urandom_range(0, 1)), f3, a, $urandom, rd, er);
      end

      // Reset during a BUSY store: no response, no commit
      req_write  = 1'b1;
      req_funct3 = 3'b010;
      req_addr   = wa(10, 0);
      req_wdata  = 32'hCAFE_F00D;
      req_valid  = 1'b1;
      while (req_ready !== 1'b1) @(negedge clk);
      @(posedge clk);
      #1;
      req_valid = 1'b0;
      @(negedge clk);
      no_resp = (resp_valid === 1'b0);
      reset_n = 1'b0;
      repeat (3) begin
         @(negedge clk);
         if (resp_valid !== 1'b0) no_resp = 1'b0;
      end
      chk("busy_reset_no_resp", 32'(no_resp), 32'd1);
      reset_n = 1'b1;
      wait_init();
      run(1'b0, 3'b010, wa(10, 0), 32'h0, rd, er);
      chk("busy_reset_word0", rd, 32'h0);
      run(1'b0, 3'b010, wa(PRE_IDX, 0), 32'h0, rd, er);
      chk("preset_after_reclear", rd, 32'hFFFF_FFE0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
